// File: rtl/ft245_dev_if_pkg.sv
// ft245_dev_if_pkg: shared definitions for the FT245 device-side endpoint.
//   - bus polarity constants (all FT245 strobes and flags are active low)
//   - default buffer depth and TXE# margin
//   - width of the optional transfer counters (FT245_DEV_ERRCHK_EN build)
//   - saturating increment helper for those counters
package ft245_dev_if_pkg;

    localparam int DEF_DEPTH_W    = 9;
    localparam int DEF_TXE_MARGIN = 2;
    localparam int ERR_CNT_W      = 16;

    // Level a host strobe has when asserted, and level a device flag has
    // when it invites a transfer.
    localparam logic STB_ON     = 1'b0;
    localparam logic FLAG_READY = 1'b0;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ft245_dev_fifo.sv
// ft245_dev_fifo: synchronous first-word-fall-through byte FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset (pointers only)
//   i_push, i_din    write strobe / data (ignored when full)
//   i_pop            read strobe (ignored when empty)
//   o_dout           current head entry, valid whenever !o_empty
//   o_full, o_empty  status
//   o_level, o_free  entries held / slots available
module ft245_dev_fifo
    import ft245_dev_if_pkg::*;
#(
    parameter int DEPTH_W = DEF_DEPTH_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [7:0]         i_din,
    input  logic               i_pop,
    output logic [7:0]         o_dout,
    output logic               o_full,
    output logic               o_empty,
    output logic [DEPTH_W:0]   o_level,
    output logic [DEPTH_W:0]   o_free
);
    typedef logic [DEPTH_W:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t CAP     = ptr_t'(1 << DEPTH_W);

    ptr_t       r_wptr;
    ptr_t       r_rptr;
    logic [7:0] r_mem [0:(1 << DEPTH_W)-1];
    logic       w_wr_en;
    logic       w_rd_en;

    assign o_level = r_wptr - r_rptr;
    assign o_free  = CAP - o_level;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[DEPTH_W] != r_rptr[DEPTH_W]) &&
                     (r_wptr[DEPTH_W-1:0] == r_rptr[DEPTH_W-1:0]);
    assign o_dout  = r_mem[r_rptr[DEPTH_W-1:0]];

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd_en) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: a slot is only visible once written.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wptr[DEPTH_W-1:0]] <= i_din;
    end

endmodule

// File: rtl/ft245_dev_if.sv
// ft245_dev_if: FT245 synchronous-FIFO device-side endpoint (the FTDI end).
// Presents RXF#/TXE#/read data to a host controller, samples RD#/WR#/OE#
// and write data, and bridges both directions to valid/accept streams.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   ftdi_rdn_i/wrn_i/oen_i     host strobes (active low)
//   ftdi_data_i                host write data
//   ftdi_rxf_no, ftdi_txe_no   device flags (active low, registered)
//   ftdi_data_o, ftdi_data_oe_o read data and pad drive enable
//   inport_*                   bytes to send to the host
//   outport_*                  bytes received from the host
// Build option FT245_DEV_ERRCHK_EN adds sticky protocol-error flags
// (err_rd_underrun_o, err_wr_overrun_o, err_bus_clash_o) and saturating
// transfer counters (rd_bytes_o, wr_bytes_o).
module ft245_dev_if
    import ft245_dev_if_pkg::*;
#(
    parameter int DEPTH_W    = DEF_DEPTH_W,
    parameter int TXE_MARGIN = DEF_TXE_MARGIN
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ftdi_rdn_i,
    input  logic                 ftdi_wrn_i,
    input  logic                 ftdi_oen_i,
    input  logic [7:0]           ftdi_data_i,
    output logic                 ftdi_rxf_no,
    output logic                 ftdi_txe_no,
    output logic [7:0]           ftdi_data_o,
    output logic                 ftdi_data_oe_o,
    input  logic                 inport_valid_i,
    input  logic [7:0]           inport_data_i,
    output logic                 inport_accept_o,
    output logic                 outport_valid_o,
    output logic [7:0]           outport_data_o,
    input  logic                 outport_accept_i
`ifdef FT245_DEV_ERRCHK_EN
    ,
    output logic                 err_rd_underrun_o,
    output logic                 err_wr_overrun_o,
    output logic                 err_bus_clash_o,
    output logic [ERR_CNT_W-1:0] rd_bytes_o,
    output logic [ERR_CNT_W-1:0] wr_bytes_o
`endif
);
    typedef logic [DEPTH_W:0] lvl_t;
    localparam lvl_t LVL_ONE = lvl_t'(1);
    localparam lvl_t MARGIN  = lvl_t'(TXE_MARGIN);

    // r_run is low for the first edge after reset release: strobes are
    // ignored on that edge so a host still in reset cannot move data.
    logic r_run;
    logic r_rxf_n;
    logic r_txe_n;
    logic r_data_oe;

    logic w_rd_stb, w_wr_stb, w_oe_stb;
    logic w_rd_push, w_rd_pop, w_rd_full, w_rd_empty;
    logic w_wr_push, w_wr_pop, w_wr_full, w_wr_empty;
    logic [7:0] w_rd_head, w_wr_head;
    lvl_t w_rd_level, w_rd_free, w_rd_level_nxt;
    lvl_t w_wr_level, w_wr_free, w_wr_free_nxt;
    logic w_unused;

    assign w_rd_stb = (ftdi_rdn_i == STB_ON);
    assign w_wr_stb = (ftdi_wrn_i == STB_ON);
    assign w_oe_stb = (ftdi_oen_i == STB_ON);

    // Device -> host
    assign w_rd_push = r_run && inport_valid_i && !w_rd_full;
    assign w_rd_pop  = r_run && w_oe_stb && w_rd_stb && (r_rxf_n == FLAG_READY);

    // Host -> device
    assign w_wr_push = r_run && w_wr_stb && (r_txe_n == FLAG_READY) && !w_wr_full;
    assign w_wr_pop  = !w_wr_empty && outport_accept_i;

    // Flags are computed from the post-edge occupancy so they are never a
    // cycle behind a push or pop.
    assign w_rd_level_nxt = w_rd_level + (w_rd_push ? LVL_ONE : '0)
                                       - (w_rd_pop  ? LVL_ONE : '0);
    assign w_wr_free_nxt  = w_wr_free  - (w_wr_push ? LVL_ONE : '0)
                                       + (w_wr_pop  ? LVL_ONE : '0);

    ft245_dev_fifo #(.DEPTH_W(DEPTH_W)) u_rd_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_rd_push),
        .i_din   (inport_data_i),
        .i_pop   (w_rd_pop),
        .o_dout  (w_rd_head),
        .o_full  (w_rd_full),
        .o_empty (w_rd_empty),
        .o_level (w_rd_level),
        .o_free  (w_rd_free)
    );

    ft245_dev_fifo #(.DEPTH_W(DEPTH_W)) u_wr_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_wr_push),
        .i_din   (ftdi_data_i),
        .i_pop   (w_wr_pop),
        .o_dout  (w_wr_head),
        .o_full  (w_wr_full),
        .o_empty (w_wr_empty),
        .o_level (w_wr_level),
        .o_free  (w_wr_free)
    );

    assign w_unused = ^{w_rd_free, w_wr_level};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run     <= 1'b0;
            r_rxf_n   <= 1'b1;
            r_txe_n   <= 1'b1;
            r_data_oe <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            r_rxf_n   <= (w_rd_level_nxt == '0);
            // Margin leaves room for writes a pipelined host issues before
            // it sees TXE# rise.
            r_txe_n   <= (w_wr_free_nxt <= MARGIN);
            // One-cycle lag after OE# gives the bus a turnaround cycle.
            r_data_oe <= r_run && w_oe_stb;
        end
    end

    assign ftdi_rxf_no     = r_rxf_n;
    assign ftdi_txe_no     = r_txe_n;
    assign ftdi_data_o     = w_rd_empty ? 8'h00 : w_rd_head;
    assign ftdi_data_oe_o  = r_data_oe;
    assign inport_accept_o = r_run && !w_rd_full;
    assign outport_valid_o = !w_wr_empty;
    assign outport_data_o  = w_wr_head;

`ifdef FT245_DEV_ERRCHK_EN
    logic                 r_err_rd, r_err_wr, r_err_clash;
    logic [ERR_CNT_W-1:0] r_rd_cnt, r_wr_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_rd    <= 1'b0;
            r_err_wr    <= 1'b0;
            r_err_clash <= 1'b0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
        end else if (r_run) begin
            if (w_oe_stb && w_rd_stb && (r_rxf_n != FLAG_READY)) r_err_rd <= 1'b1;
            if (w_wr_stb && (r_txe_n != FLAG_READY))             r_err_wr <= 1'b1;
            if (w_oe_stb && w_wr_stb)                            r_err_clash <= 1'b1;
            if (w_rd_pop)  r_rd_cnt <= sat_inc(r_rd_cnt);
            if (w_wr_push) r_wr_cnt <= sat_inc(r_wr_cnt);
        end
    end

    assign err_rd_underrun_o = r_err_rd;
    assign err_wr_overrun_o  = r_err_wr;
    assign err_bus_clash_o   = r_err_clash;
    assign rd_bytes_o        = r_rd_cnt;
    assign wr_bytes_o        = r_wr_cnt;
`endif

endmodule

// File: tb/tb_ft245_dev_if.sv
// Bench for ft245_dev_if: a queue-based model of both buffers checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_ft245_dev_if;
    localparam int CAP    = 512;
    localparam int MARGIN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rdn, wrn, oen;
    logic [7:0] din;
    logic       rxf_n, txe_n, data_oe;
    logic [7:0] dout;
    logic       in_valid, in_accept;
    logic [7:0] in_data;
    logic       out_valid, out_accept;
    logic [7:0] out_data;
`ifdef FT245_DEV_ERRCHK_EN
    logic        err_rd, err_wr, err_clash;
    logic [15:0] rd_bytes, wr_bytes;
`endif

    always #5 clk = ~clk;

    ft245_dev_if dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .ftdi_rdn_i       (rdn),
        .ftdi_wrn_i       (wrn),
        .ftdi_oen_i       (oen),
        .ftdi_data_i      (din),
        .ftdi_rxf_no      (rxf_n),
        .ftdi_txe_no      (txe_n),
        .ftdi_data_o      (dout),
        .ftdi_data_oe_o   (data_oe),
        .inport_valid_i   (in_valid),
        .inport_data_i    (in_data),
        .inport_accept_o  (in_accept),
        .outport_valid_o  (out_valid),
        .outport_data_o   (out_data),
        .outport_accept_i (out_accept)
`ifdef FT245_DEV_ERRCHK_EN
        ,
        .err_rd_underrun_o (err_rd),
        .err_wr_overrun_o  (err_wr),
        .err_bus_clash_o   (err_clash),
        .rd_bytes_o        (rd_bytes),
        .wr_bytes_o        (wr_bytes)
`endif
    );

    int checks = 0;
    int failures = 0;
    int in_sent = 0;
    int wr_sent = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] rdq[$];
    logic [7:0] wrq[$];
    logic [7:0] host_rx[$];
    logic [7:0] out_rx[$];
    bit m_rxf = 1'b1, m_txe = 1'b1, m_oe = 1'b0, m_run = 1'b0;
    bit model_on = 1'b0;

    always @(negedge clk) begin
        bit rd_pop, rd_push, wr_push, wr_pop;
        if (model_on) begin
            if (!rst_n) begin
                rdq.delete(); wrq.delete();
                m_rxf = 1'b1; m_txe = 1'b1; m_oe = 1'b0; m_run = 1'b0;
            end
            chk("rxf_no", 32'(rxf_n), 32'(m_rxf));
            chk("txe_no", 32'(txe_n), 32'(m_txe));
            chk("data_oe", 32'(data_oe), 32'(m_oe));
            chk("inport_accept", 32'(in_accept), 32'(m_run && rdq.size() < CAP));
            chk("outport_valid", 32'(out_valid), 32'(wrq.size() != 0));
            if (rdq.size() != 0) chk("ftdi_data", 32'(dout), 32'(rdq[0]));
            if (wrq.size() != 0) chk("outport_data", 32'(out_data), 32'(wrq[0]));
            if (rst_n) begin
                rd_pop  = m_run && !oen && !rdn && !m_rxf;
                rd_push = m_run && in_valid && rdq.size() < CAP;
                wr_push = m_run && !wrn && !m_txe;
                wr_pop  = wrq.size() != 0 && out_accept;
                if (rd_pop) begin
                    host_rx.push_back(dout);
                    void'(rdq.pop_front());
                end
                if (rd_push) rdq.push_back(in_data);
                if (wr_pop) begin
                    out_rx.push_back(out_data);
                    void'(wrq.pop_front());
                end
                if (wr_push) wrq.push_back(din);
                m_oe  = m_run && !oen;
                m_rxf = (rdq.size() == 0);
                m_txe = ((CAP - wrq.size()) <= MARGIN);
                m_run = 1'b1;
            end
        end
    end

    // One clock; a handshaking source/host advances its data after each
    // accepted transfer.
    task automatic step();
        bit in_f, wr_f;
        in_f = in_valid && in_accept;
        wr_f = !wrn && !txe_n;
        @(posedge clk); #1;
        if (in_f) begin in_data = in_data + 8'd1; in_sent++; end
        if (wr_f) begin din = din + 8'd1; wr_sent++; end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int base, wbase, bad, got, s0, w0;
        logic [7:0] in0, wd0;
        rdn = 1; wrn = 1; oen = 1; din = 0;
        in_valid = 0; in_data = 0; out_accept = 0;
        #1 rst_n = 0;
        #1;
        // reset values
        chk("rst_rxf", 32'(rxf_n), 1);
        chk("rst_txe", 32'(txe_n), 1);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_oe", 32'(data_oe), 0);
        chk("rst_accept", 32'(in_accept), 0);
        chk("rst_outvalid", 32'(out_valid), 0);
        model_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) step();

        // T1: 16 bytes device->host
        in_valid = 1; in_data = 0;
        for (int n = 0; n < 100 && in_data != 8'h10; n++) step();
        in_valid = 0;
        chk("t1_rxf_low", 32'(rxf_n), 0);
        base = host_rx.size();
        rdn = 0;
        repeat (3) step();                      // RD# without OE#: no pop
        chk("t1_no_oe_pop", 32'(host_rx.size() - base), 0);
        chk("t1_no_oe_rxf", 32'(rxf_n), 0);
        rdn = 1; oen = 0;
        step();
        chk("t1_oe_lag", 32'(data_oe), 1);
        rdn = 0;
        repeat (20) step();
        rdn = 1; oen = 1;
        chk("t1_count", 32'(host_rx.size() - base), 16);
        for (int i = 0; i < 16 && base + i < host_rx.size(); i++)
            chk("t1_byte", 32'(host_rx[base + i]), 32'(i));
        chk("t1_rxf_high", 32'(rxf_n), 1);

        // T2: fill host->device with outport stalled
        din = 0; out_accept = 0; wrn = 0;
        repeat (520) step();
        wrn = 1;
        chk("t2_txe_high", 32'(txe_n), 1);
        chk("t2_stored", 32'(wrq.size()), 510);
        base = out_rx.size();
        out_accept = 1;
        repeat (520) step();
        out_accept = 0;
        chk("t2_drained", 32'(out_rx.size() - base), 510);
        bad = 0;
        for (int i = 0; i < 510 && base + i < out_rx.size(); i++)
            if (out_rx[base + i] !== 8'(i)) bad++;
        chk("t2_order", 32'(bad), 0);
        chk("t2_txe_low", 32'(txe_n), 0);

        // T3: concurrent traffic with random stalls
        base = host_rx.size(); wbase = out_rx.size();
        s0 = in_sent; w0 = wr_sent; in0 = in_data; wd0 = din;
        oen = 0; in_valid = 1;
        repeat (4000) begin
            rdn = ($urandom_range(7) == 0);
            wrn = ($urandom_range(4) == 0);
            out_accept = ($urandom_range(3) != 0);
            step();
        end
        in_valid = 0; wrn = 1; rdn = 0; out_accept = 1;
        repeat (600) step();
        rdn = 1; oen = 1; out_accept = 0;
        got = host_rx.size() - base;
        chk("t3_rd_count", 32'(got), 32'(in_sent - s0));
        chk("t3_rd_wraps", 32'(got > 3 * CAP), 1);
        bad = 0;
        for (int i = 0; i < got; i++) if (host_rx[base + i] !== 8'(in0 + 8'(i))) bad++;
        chk("t3_rd_order", 32'(bad), 0);
        got = out_rx.size() - wbase;
        chk("t3_wr_count", 32'(got), 32'(wr_sent - w0));
        chk("t3_wr_wraps", 32'(got > 3 * CAP), 1);
        bad = 0;
        for (int i = 0; i < got; i++) if (out_rx[wbase + i] !== 8'(wd0 + 8'(i))) bad++;
        chk("t3_wr_order", 32'(bad), 0);

        // T4: reset in the middle of a read burst
        in_valid = 1;
        repeat (8) step();
        in_valid = 0; wrn = 0;
        repeat (5) step();
        wrn = 1; oen = 0; rdn = 0;
        repeat (2) step();
        rst_n = 0;
        #1;
        chk("t4_rxf_async", 32'(rxf_n), 1);
        chk("t4_txe_async", 32'(txe_n), 1);
        chk("t4_valid_async", 32'(out_valid), 0);
        chk("t4_accept_async", 32'(in_accept), 0);
        step(); step();
        rst_n = 1;
        step(); step();
        chk("t4_rxf_empty", 32'(rxf_n), 1);
        chk("t4_out_empty", 32'(out_valid), 0);
        chk("t4_oe_back", 32'(data_oe), 1);
        rdn = 1; oen = 1;
        step();

`ifdef FT245_DEV_ERRCHK_EN
        // T5: sticky error flags, counters untouched by rejected strobes
        chk("t5_ovr_clear", 32'(err_wr), 0);
        chk("t5_clash_clear", 32'(err_clash), 0);
        oen = 0; rdn = 0; step();
        rdn = 1; oen = 1; step();
        chk("t5_underrun", 32'(err_rd), 1);
        chk("t5_rd_bytes", 32'(rd_bytes), 0);
        wrn = 0;
        repeat (515) step();
        wrn = 1; step();
        chk("t5_overrun", 32'(err_wr), 1);
        chk("t5_wr_bytes", 32'(wr_bytes), 510);
        chk("t5_underrun_sticky", 32'(err_rd), 1);
        chk("t5_no_clash", 32'(err_clash), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
